// File: rtl/jacobi2d_pkg.sv
// Shared types and constants for the jacobi2d stage-buffer read side.
package jacobi2d_pkg;

  localparam int LANES   = 4;
  localparam int PIXEL_W = 16;

  typedef logic [PIXEL_W-1:0]  pixel_t;
  typedef pixel_t [LANES-1:0]  word_t;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    STREAM,
    FLUSH,
    DONE
  } state_t;

endpackage

// File: rtl/jacobi2d_line_buffer.sv
// One row of 4-pixel words with a single shared read/write address.
// Reads are combinational and return the old word during a same-address write.
module jacobi2d_line_buffer
  import jacobi2d_pkg::*;
#(
  parameter int  DW    = 16,
  parameter int  DEPTH = 16,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                clk,
  input  logic                we,
  input  logic [AW-1:0]       addr,
  input  logic [LANES*DW-1:0] wdata,
  output logic [LANES*DW-1:0] rdata
);

  logic [LANES*DW-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  // NOTE: storage arrays take no reset; their contents are always written before being read.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/jacobi2d_stencil_reader.sv
// Buffers two rows of the raster input stream and emits the 5-point cross
// neighbourhood for four adjacent centre pixels per beat.
module jacobi2d_stencil_reader
  import jacobi2d_pkg::*;
#(
  parameter int DW = 16,
  parameter int W  = 64,
  parameter int H  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*DW-1:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*DW-1:0]   out_c,
  output logic [4*DW-1:0]   out_n,
  output logic [4*DW-1:0]   out_s,
  output logic [4*DW-1:0]   out_w,
  output logic [4*DW-1:0]   out_e
);

  localparam int WPR = W / LANES;
  localparam int XW  = $clog2(WPR);
  localparam int YW  = $clog2(H);

  typedef logic [LANES-1:0][DW-1:0] lanes_t;

  state_t        state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          sel;        // 1: physical buffer B holds the older row
  lanes_t        s_q;        // previous input word, south row of the next window
  lanes_t        c_q;        // centre word x-1 read ahead from LB1
  logic [DW-1:0] left_px_q;  // lane 3 of centre word x-2

  logic accept, out_free, last_x, load_win, left_clamp;
  assign out_free = !out_valid || out_ready;
  assign in_ready = ((state == FILL) || (state == STREAM)) && out_free;
  assign accept   = in_valid && in_ready;
  assign last_x   = (x == XW'(WPR - 1));
  assign load_win = ((state == STREAM) && accept && (x != '0)) ||
                    ((state == FLUSH) && out_free);
  assign left_clamp = (state == STREAM) && (x == XW'(1));

  logic          lb0_we, lb1_we, a_we, b_we;
  logic [XW-1:0] lb0_addr, lb1_addr, a_addr, b_addr;
  lanes_t        lb0_wdata, lb1_wdata, a_wdata, b_wdata;
  lanes_t        lb0_rdata, lb1_rdata, a_rdata, b_rdata;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    lb0_we    = 1'b0;
    lb1_we    = 1'b0;
    lb0_addr  = x;
    lb1_addr  = x;
    lb0_wdata = in_data;
    lb1_wdata = in_data;
    case (state)
      FILL: begin
        lb0_we = accept && (y == '0);
        lb1_we = accept && (y != '0);
      end
      // The older row is overwritten with row y one word behind its last read.
      STREAM: begin
        lb0_addr  = x - 1'b1;
        lb0_wdata = s_q;
        lb0_we    = accept && (x != '0);
      end
      FLUSH: begin
        lb0_addr  = XW'(WPR - 1);
        lb0_wdata = s_q;
        lb0_we    = out_free;
      end
      default: ;
    endcase
  end

  // Logical LB0/LB1 onto the two physical buffers; rotation just flips sel.
  assign a_we      = sel ? lb1_we    : lb0_we;
  assign a_addr    = sel ? lb1_addr  : lb0_addr;
  assign a_wdata   = sel ? lb1_wdata : lb0_wdata;
  assign b_we      = sel ? lb0_we    : lb1_we;
  assign b_addr    = sel ? lb0_addr  : lb1_addr;
  assign b_wdata   = sel ? lb0_wdata : lb1_wdata;
  assign lb0_rdata = sel ? b_rdata   : a_rdata;
  assign lb1_rdata = sel ? a_rdata   : b_rdata;

  jacobi2d_line_buffer #(.DW(DW), .DEPTH(WPR)) u_lb_a (
    .clk   (clk),
    .we    (a_we),
    .addr  (a_addr),
    .wdata (a_wdata),
    .rdata (a_rdata)
  );

  jacobi2d_line_buffer #(.DW(DW), .DEPTH(WPR)) u_lb_b (
    .clk   (clk),
    .we    (b_we),
    .addr  (b_addr),
    .wdata (b_wdata),
    .rdata (b_rdata)
  );

  lanes_t win_w, win_e;

  always_comb begin
    win_w = '0;
    win_e = '0;
    win_w[0] = left_clamp ? c_q[0] : left_px_q;
    for (int i = 1; i < LANES; i++) win_w[i] = c_q[i-1];
    for (int i = 0; i < LANES - 1; i++) win_e[i] = c_q[i+1];
    win_e[LANES-1] = (state == FLUSH) ? c_q[LANES-1] : lb1_rdata[0];
  end

  // NOTE: non-blocking assignments for all registered state, so every read sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      x         <= '0;
      y         <= '0;
      sel       <= 1'b0;
      done      <= 1'b0;
      s_q       <= '0;
      c_q       <= '0;
      left_px_q <= '0;
      out_valid <= 1'b0;
      out_c     <= '0;
      out_n     <= '0;
      out_s     <= '0;
      out_w     <= '0;
      out_e     <= '0;
    end else begin
      if (load_win) begin
        out_valid <= 1'b1;
        out_c     <= c_q;
        out_n     <= lb0_rdata;
        out_s     <= s_q;
        out_w     <= win_w;
        out_e     <= win_e;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= FILL;
            x     <= '0;
            y     <= '0;
            sel   <= 1'b0;
            done  <= 1'b0;
          end else if ((state == DONE) && out_free) begin
            done <= 1'b1;
          end
        end
        FILL: begin
          if (accept) begin
            if (last_x) begin
              x <= '0;
              if (y == YW'(1)) begin
                y     <= YW'(2);
                state <= STREAM;
              end else begin
                y <= y + 1'b1;
              end
            end else begin
              x <= x + 1'b1;
            end
          end
        end
        STREAM: begin
          if (accept) begin
            s_q       <= in_data;
            c_q       <= lb1_rdata;
            left_px_q <= c_q[LANES-1];
            if (last_x) state <= FLUSH;
            else        x     <= x + 1'b1;
          end
        end
        FLUSH: begin
          if (out_free) begin
            sel <= ~sel;
            x   <= '0;
            if (y == YW'(H - 1)) begin
              state <= DONE;
            end else begin
              y     <= y + 1'b1;
              state <= STREAM;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jacobi2d_stencil_reader.sv
// Directed bench for jacobi2d_stencil_reader on an 8x4 image, pixel(y,x) = y*8+x.
module tb_jacobi2d_stencil_reader;
  import jacobi2d_pkg::*;

  localparam int DW     = 16;
  localparam int W      = 8;
  localparam int H      = 4;
  localparam int WPR    = W / 4;
  localparam int NWORDS = WPR * H;
  localparam int NWIN   = (H - 2) * WPR;

  logic  clk = 1'b0;
  logic  rst, start, done, in_valid, in_ready, out_valid, out_ready;
  word_t in_data, out_c, out_n, out_s, out_w, out_e;

  always #5 clk = ~clk;

  jacobi2d_stencil_reader #(.DW(DW), .W(W), .H(H)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .done      (done),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_c     (out_c),
    .out_n     (out_n),
    .out_s     (out_s),
    .out_w     (out_w),
    .out_e     (out_e)
  );

  typedef struct packed {
    word_t c, n, s, w, e;
  } win_t;

  win_t exp_tab [NWIN];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic word_t mk(input int a, input int b, input int c, input int d);
    word_t r;
    r[0] = pixel_t'(a);
    r[1] = pixel_t'(b);
    r[2] = pixel_t'(c);
    r[3] = pixel_t'(d);
    return r;
  endfunction

  function automatic word_t add_ofs(input word_t w, input int o);
    word_t r;
    for (int i = 0; i < 4; i++) r[i] = w[i] + pixel_t'(o);
    return r;
  endfunction

  function automatic word_t pix_word(input int idx, input int o);
    int yy, xx;
    yy = idx / WPR;
    xx = idx % WPR;
    return mk(o + yy*8 + xx*4, o + yy*8 + xx*4 + 1, o + yy*8 + xx*4 + 2, o + yy*8 + xx*4 + 3);
  endfunction

  // Streams one frame; stall_win < 0 disables backpressure, abort_win > 0 returns early.
  task automatic run_frame(input int ofs, input bit bubble, input int stall_win, input int abort_win);
    int    idx = 0;
    int    widx = 0;
    int    cyc = 0;
    int    stalled = 0;
    bit    finished = 1'b0;
    word_t snap_c, snap_e;
    win_t  ex;
    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done_drop_after_start", done, 1'b0);
    while (!finished && cyc < 200) begin
      if (widx == NWIN) begin
        check("done_after_last_window", done, 1'b1);
        check("in_ready_in_done", in_ready, 1'b0);
        finished = 1'b1;
      end else begin
        in_valid  = (idx < NWORDS) && (!bubble || (cyc % 2 == 0));
        in_data   = (idx < NWORDS) ? pix_word(idx, ofs) : '0;
        out_ready = 1'b1;
        if (stall_win == widx && out_valid && stalled < 5) begin
          out_ready = 1'b0;
          if (stalled == 0) begin
            snap_c = out_c;
            snap_e = out_e;
          end else begin
            check("stall_valid_held", out_valid, 1'b1);
            check("stall_c_stable", out_c, snap_c);
            check("stall_e_stable", out_e, snap_e);
          end
          stalled++;
        end
        #1;
        if (!out_ready) check("stall_in_ready_low", in_ready, 1'b0);
        if (in_valid && in_ready) idx++;
        if (out_valid && out_ready) begin
          ex = exp_tab[widx];
          check($sformatf("win%0d_c", widx), out_c, add_ofs(ex.c, ofs));
          check($sformatf("win%0d_n", widx), out_n, add_ofs(ex.n, ofs));
          check($sformatf("win%0d_s", widx), out_s, add_ofs(ex.s, ofs));
          check($sformatf("win%0d_w", widx), out_w, add_ofs(ex.w, ofs));
          check($sformatf("win%0d_e", widx), out_e, add_ofs(ex.e, ofs));
          widx++;
          if (widx == NWIN) check("done_low_before_last_accept", done, 1'b0);
          if (abort_win > 0 && widx == abort_win) finished = 1'b1;
        end
        if (!finished) @(negedge clk);
        cyc++;
      end
    end
    if (!finished) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: got %0d windows expected %0d", widx, NWIN);
    end
    if (stall_win >= 0 && stalled != 5) begin
      checks++;
      errors++;
      $display("FAIL stall_cycles: got %0d expected 5", stalled);
    end
  endtask

  initial begin
    // Centre words (1,0), (1,1), (2,0), (2,1) of the 8x4 frame.
    exp_tab[0] = '{c: mk( 8,  9, 10, 11), n: mk( 0,  1,  2,  3), s: mk(16, 17, 18, 19),
                   w: mk( 8,  8,  9, 10), e: mk( 9, 10, 11, 12)};
    exp_tab[1] = '{c: mk(12, 13, 14, 15), n: mk( 4,  5,  6,  7), s: mk(20, 21, 22, 23),
                   w: mk(11, 12, 13, 14), e: mk(13, 14, 15, 15)};
    exp_tab[2] = '{c: mk(16, 17, 18, 19), n: mk( 8,  9, 10, 11), s: mk(24, 25, 26, 27),
                   w: mk(16, 16, 17, 18), e: mk(17, 18, 19, 20)};
    exp_tab[3] = '{c: mk(20, 21, 22, 23), n: mk(12, 13, 14, 15), s: mk(28, 29, 30, 31),
                   w: mk(19, 20, 21, 22), e: mk(21, 22, 23, 23)};

    rst       = 1'b1;
    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    repeat (3) @(negedge clk);
    check("reset_done", done, 1'b0);
    check("reset_in_ready", in_ready, 1'b0);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_c", out_c, '0);
    check("reset_out_e", out_e, '0);
    rst = 1'b0;

    run_frame(0, 1'b0, -1, 0);
    run_frame(0, 1'b0, 1, 0);
    run_frame(0, 1'b1, -1, 0);

    run_frame(0, 1'b0, -1, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_in_ready", in_ready, 1'b0);
    check("midrst_done", done, 1'b0);
    rst      = 1'b0;
    in_valid = 1'b0;
    run_frame(0, 1'b0, -1, 0);

    run_frame(100, 1'b0, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
